// File: rtl/axi_reg_pkg.sv
// Shared types and constants for the single-outstanding AXI register master.
// Provides the FSM state encoding, AXI response codes and bus widths.
package axi_reg_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_B,
      ST_RD_A,
      ST_RD_D,
      ST_RSP
   } state_t;

   // Counter width able to hold values 0..limit.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/axi_wait_timer.sv
// Saturating wait-cycle counter with a sticky expiry flag.
// A limit of 0 disables expiry entirely; clear restarts the count but never clears expired.
module axi_wait_timer
   import axi_reg_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int              CW      = cnt_width(LIMIT);
   localparam logic [CW-1:0]   LIMIT_C = CW'(LIMIT);
   localparam bit              ENABLED = (LIMIT != 0);

   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      count_nxt = count;
      if (clear) begin
         count_nxt = '0;
      end else if (enable && (count != LIMIT_C)) begin
         count_nxt = count + CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         expired <= 1'b0;
      end else begin
         count <= count_nxt;
         if (ENABLED && (count_nxt == LIMIT_C)) begin
            expired <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/m_axi_reg_master.sv
// Single-outstanding AXI initiator: turns one command into a one-beat AXI write or read,
// checks returned IDs / rlast, reports the response code and flags stalled transactions.
module m_axi_reg_master
   import axi_reg_pkg::*;
#(
   parameter logic [ID_W-1:0] AXI_ID         = 4'h1,
   parameter int              TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   input  logic [STRB_W-1:0] cmd_wstrb_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic [1:0]        rsp_resp_o,
   output logic              timeout_o,
   output logic [ID_W-1:0]   awid_o,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic              awvalid_o,
   input  logic              awready_i,
   output logic [ID_W-1:0]   wid_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [STRB_W-1:0] wstrb_o,
   output logic              wlast_o,
   output logic              wvalid_o,
   input  logic              wready_i,
   input  logic [ID_W-1:0]   bid_i,
   input  logic [1:0]        bresp_i,
   input  logic              bvalid_i,
   output logic              bready_o,
   output logic [ID_W-1:0]   arid_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [ID_W-1:0]   rid_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              rlast_i,
   input  logic              rvalid_i,
   output logic              rready_o
);

   state_t state, state_nxt;

   logic              cmd_ready_nxt;
   logic              awvalid_nxt;
   logic              wvalid_nxt;
   logic              bready_nxt;
   logic              arvalid_nxt;
   logic              rready_nxt;
   logic              rsp_valid_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [STRB_W-1:0] wstrb_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic [1:0]        rsp_resp_nxt;

   logic accept;
   logic aw_done;
   logic w_done;
   logic waiting;

   assign awid_o   = AXI_ID;
   assign wid_o    = AXI_ID;
   assign arid_o   = AXI_ID;
   assign wlast_o  = 1'b1;
   assign awaddr_o = addr;
   assign araddr_o = addr;

   assign accept  = (state == ST_IDLE) && cmd_valid_i;
   // A channel is done once its valid has dropped or it handshakes this cycle.
   assign aw_done = !awvalid_o || awready_i;
   assign w_done  = !wvalid_o || wready_i;
   assign waiting = (state == ST_WR) || (state == ST_WR_B) ||
                    (state == ST_RD_A) || (state == ST_RD_D);

   always_comb begin
      state_nxt     = state;
      cmd_ready_nxt = cmd_ready_o;
      awvalid_nxt   = awvalid_o;
      wvalid_nxt    = wvalid_o;
      bready_nxt    = bready_o;
      arvalid_nxt   = arvalid_o;
      rready_nxt    = rready_o;
      rsp_valid_nxt = rsp_valid_o;
      addr_nxt      = addr;
      wdata_nxt     = wdata_o;
      wstrb_nxt     = wstrb_o;
      rsp_rdata_nxt = rsp_rdata_o;
      rsp_resp_nxt  = rsp_resp_o;

      case (state)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               cmd_ready_nxt = 1'b0;
               addr_nxt      = cmd_addr_i;
               wdata_nxt     = cmd_wdata_i;
               wstrb_nxt     = cmd_wstrb_i;
               if (cmd_write_i) begin
                  state_nxt   = ST_WR;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
               end else begin
                  state_nxt   = ST_RD_A;
                  arvalid_nxt = 1'b1;
               end
            end
         end

         ST_WR: begin
            if (awvalid_o && awready_i) awvalid_nxt = 1'b0;
            if (wvalid_o && wready_i)   wvalid_nxt  = 1'b0;
            if (aw_done && w_done) begin
               state_nxt  = ST_WR_B;
               bready_nxt = 1'b1;
            end
         end

         ST_WR_B: begin
            if (bvalid_i) begin
               state_nxt     = ST_RSP;
               bready_nxt    = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = '0;
               rsp_resp_nxt  = (bid_i != AXI_ID) ? RESP_SLVERR : bresp_i;
            end
         end

         ST_RD_A: begin
            if (arready_i) begin
               state_nxt   = ST_RD_D;
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
            end
         end

         ST_RD_D: begin
            if (rvalid_i) begin
               state_nxt     = ST_RSP;
               rready_nxt    = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = rdata_i;
               rsp_resp_nxt  = ((rid_i != AXI_ID) || !rlast_i) ? RESP_SLVERR : RESP_OKAY;
            end
         end

         ST_RSP: begin
            if (rsp_ready_i) begin
               state_nxt     = ST_IDLE;
               rsp_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt     = ST_IDLE;
            cmd_ready_nxt = 1'b1;
            awvalid_nxt   = 1'b0;
            wvalid_nxt    = 1'b0;
            bready_nxt    = 1'b0;
            arvalid_nxt   = 1'b0;
            rready_nxt    = 1'b0;
            rsp_valid_nxt = 1'b0;
         end
      endcase
   end

   // Payload registers are reset too, so a dropped transaction leaves no stale address/data on the bus.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state       <= ST_IDLE;
         cmd_ready_o <= 1'b1;
         awvalid_o   <= 1'b0;
         wvalid_o    <= 1'b0;
         bready_o    <= 1'b0;
         arvalid_o   <= 1'b0;
         rready_o    <= 1'b0;
         rsp_valid_o <= 1'b0;
         addr        <= '0;
         wdata_o     <= '0;
         wstrb_o     <= '0;
         rsp_rdata_o <= '0;
         rsp_resp_o  <= RESP_OKAY;
      end else begin
         state       <= state_nxt;
         cmd_ready_o <= cmd_ready_nxt;
         awvalid_o   <= awvalid_nxt;
         wvalid_o    <= wvalid_nxt;
         bready_o    <= bready_nxt;
         arvalid_o   <= arvalid_nxt;
         rready_o    <= rready_nxt;
         rsp_valid_o <= rsp_valid_nxt;
         addr        <= addr_nxt;
         wdata_o     <= wdata_nxt;
         wstrb_o     <= wstrb_nxt;
         rsp_rdata_o <= rsp_rdata_nxt;
         rsp_resp_o  <= rsp_resp_nxt;
      end
   end

   axi_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (areset),
      .clear   (accept),
      .enable  (waiting),
      .expired (timeout_o)
   );

endmodule

// File: doc/m_axi_reg_master.md
Name: m_axi_reg_master

Overview:
Single-outstanding AXI initiator that converts a simple command/response interface into one-beat AXI write or read transactions. It drives the 32-bit, 4-bit-ID register slave port used across the design, so firmware-side logic and benches can access register banks without hand-driving AXI channels. It checks returned IDs, reports response codes and flags stalled transactions.

Parameters:
AXI_ID, 4'h1, constant ID driven on awid_o/wid_o/arid_o and expected on bid_i/rid_i
TIMEOUT_CYCLES, 255, wait-cycle limit per transaction before timeout_o is set; 0 disables the timer

Ports:
clk  in  1  clock
areset  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  32  register address
cmd_wdata_i  in  32  write data
cmd_wstrb_i  in  4  write byte strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  32  read data (0 for writes)
rsp_resp_o  out  2  0 OKAY, 2 SLVERR (bresp_i, or forced on ID mismatch / missing rlast)
timeout_o  out  1  sticky: a transaction exceeded TIMEOUT_CYCLES
awid_o  out  4  =AXI_ID
awaddr_o  out  32  write address
awvalid_o  out  1  write address valid
awready_i  in  1  write address ready
wid_o  out  4  =AXI_ID
wdata_o  out  32  write data
wstrb_o  out  4  write strobes
wlast_o  out  1  tied 1 (single beat)
wvalid_o  out  1  write data valid
wready_i  in  1  write data ready
bid_i  in  4  response ID
bresp_i  in  2  write response
bvalid_i  in  1  response valid
bready_o  out  1  response ready
arid_o  out  4  =AXI_ID
araddr_o  out  32  read address
arvalid_o  out  1  read address valid
arready_i  in  1  read address ready
rid_i  in  4  read ID
rdata_i  in  32  read data
rlast_i  in  1  last beat
rvalid_i  in  1  read data valid
rready_o  out  1  read data ready

Behaviour:
- Reset (areset low, async): state IDLE; all valid/ready outputs 0 except cmd_ready_o=1; addr/data/strb/rsp fields 0; timeout_o 0; timer 0. Reset mid-transaction drops it with no response.
- States: IDLE, WR, WR_B, RD_A, RD_D, RSP. cmd_ready_o=1 only in IDLE.
- IDLE: on cmd_valid_i&&cmd_ready_o (cycle T), register addr/data/strb; go WR (write) or RD_A (read). AXI valids rise at T+1, all registered.
- WR: awvalid_o and wvalid_o both asserted at entry; each drops the cycle after its own handshake and never re-asserts; same-cycle handshakes, or either order, both legal. When both done -> WR_B. Payload stable while valid high.
- WR_B: bready_o=1; on bvalid_i: rsp_resp_o = (bid_i!=AXI_ID) ? 2 : bresp_i; rsp_rdata_o=0; -> RSP.
- RD_A: arvalid_o=1 until arready_i; -> RD_D. RD_D: rready_o=1; on rvalid_i: capture rdata_i; rsp_resp_o=2 if rid_i!=AXI_ID or !rlast_i, else 0; -> RSP.
- RSP: rsp_valid_o=1 until rsp_ready_i; then IDLE (next command accepted earliest one cycle later). Min latency accept->rsp_valid_o: 3 cycles with zero-wait slave.
- Timer: cleared on command accept, increments each non-IDLE/non-RSP cycle, saturates; reaching TIMEOUT_CYCLES sets timeout_o (sticky until reset). Transaction is never aborted.
- Spurious bvalid_i/rvalid_i outside WR_B/RD_D: ignored (ready low).

Decomposition:
- Package axi_reg_pkg: state enum, RESP_OKAY=2'b00/RESP_SLVERR=2'b10, ID/addr/data widths.
- Sub-module axi_wait_timer (clear, enable, saturating count, sticky expired).

Test Plan:
- Write addr 3, data 32'hA5A5_1234, strb 4'hF, zero-wait slave -> one aw/w handshake each, wlast_o=1, rsp_resp_o=0, rsp_valid_o 3 cycles after accept.
- Read addr 3 after write -> rsp_rdata_o=32'hA5A5_1234, rsp_resp_o=0.
- awready_i delayed 4 cycles, wready_i immediate -> wvalid_o drops after 1 cycle, awvalid_o held 5, single response.
- Slave returns bid_i=4'h7 -> rsp_resp_o=2; rid_i ok but rlast_i=0 -> rsp_resp_o=2.
- TIMEOUT_CYCLES=8, bvalid_i withheld 20 cycles -> timeout_o rises in WR_B, transaction completes normally, timeout_o stays 1.
- rsp_ready_i low 5 cycles with cmd_valid_i high -> cmd_ready_o 0 throughout, rsp stable; areset pulse mid-WR -> all outputs to reset values.
